// File: rtl/simd_vec_sequencer_if.sv
// Issue/result bus for the SIMD vector sequencer.
// Carries the instruction handshake, the ALU lane bank and the result handshake.
interface simd_vec_sequencer_if #(
  parameter int W    = 8,
  parameter int VLEN = 8,
  parameter int NALU = 4
);
  logic              in_valid;
  logic              in_ready;
  logic [2:0]        in_op;
  logic [VLEN*W-1:0] in_a;
  logic [VLEN*W-1:0] in_b;
  logic [2:0]        alu_ctrl;
  logic [NALU*W-1:0] alu_a;
  logic [NALU*W-1:0] alu_b;
  logic [NALU*W-1:0] alu_c;
  logic              out_valid;
  logic              out_ready;
  logic [VLEN*W-1:0] out_c;
  logic              busy;

  modport master (
    output in_valid, in_op, in_a, in_b, alu_c, out_ready,
    input  in_ready, alu_ctrl, alu_a, alu_b, out_valid, out_c, busy
  );

  modport slave (
    input  in_valid, in_op, in_a, in_b, alu_c, out_ready,
    output in_ready, alu_ctrl, alu_a, alu_b, out_valid, out_c, busy
  );
endinterface

// File: rtl/simd_vec_sequencer.sv
// Slices a VLEN-element vector op into NALU-wide beats for external ALU lanes
// and reassembles the lane results into one result vector.
module simd_vec_sequencer #(
  parameter int W    = 8,
  parameter int VLEN = 8,
  parameter int NALU = 4
) (
  input logic                clk,
  input logic                rst,
  simd_vec_sequencer_if.slave bus
);
  localparam int BEATS = VLEN / NALU;
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BW-1:0] LAST = BW'(BEATS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [BW-1:0]     beat_q, beat_d;
  logic [2:0]        op_q, op_d;
  logic [VLEN*W-1:0] a_q, a_d;
  logic [VLEN*W-1:0] b_q, b_d;
  logic [VLEN*W-1:0] out_c_q, out_c_d;

  logic in_ready;
  logic fire_in;
  logic fire_out;

  assign in_ready = (state_q == IDLE) && !rst;
  assign fire_in  = bus.in_valid && in_ready;
  assign fire_out = (state_q == DONE) && bus.out_ready;

  // State and datapath registers, cleared asynchronously
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      beat_q  <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      out_c_q <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      out_c_q <= out_c_d;
    end
  end

  // Next-state: accept in IDLE, walk the beats, hold result until taken
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (fire_in) state_d = EXEC;
      EXEC:    if (beat_q == LAST) state_d = DONE;
      DONE:    if (fire_out) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Capture the instruction, advance the beat, merge lane results
  always_comb begin
    beat_d  = beat_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    out_c_d = out_c_q;
    if (state_q == IDLE && fire_in) begin
      op_d   = bus.in_op;
      a_d    = bus.in_a;
      b_d    = bus.in_b;
      beat_d = '0;
    end else if (state_q == EXEC) begin
      for (int k = 0; k < NALU; k++) begin
        out_c_d[(int'(beat_q) * NALU + k) * W +: W] = bus.alu_c[k * W +: W];
      end
      beat_d = (beat_q == LAST) ? '0 : beat_q + BW'(1);
    end
  end

  // Outputs: lanes fed only during EXEC, op held between instructions
  always_comb begin
    bus.alu_a     = '0;
    bus.alu_b     = '0;
    bus.alu_ctrl  = op_q;
    bus.in_ready  = in_ready;
    bus.out_valid = (state_q == DONE);
    bus.busy      = (state_q != IDLE);
    bus.out_c     = out_c_q;
    if (state_q == EXEC) begin
      for (int k = 0; k < NALU; k++) begin
        bus.alu_a[k * W +: W] = a_q[(int'(beat_q) * NALU + k) * W +: W];
        bus.alu_b[k * W +: W] = b_q[(int'(beat_q) * NALU + k) * W +: W];
      end
    end
  end
endmodule
